mem_access_ctrl: RTL and testbench
==================================

Name: mem_access_ctrl

Overview:
Sequences all data-memory accesses from the MEM stage over a single-port, word-wide synchronous data RAM with no byte enables. Loads are performed as word reads followed by sub-word extraction with sign or zero extension. Sub-word stores are performed as read-modify-write. Misaligned or illegal accesses are flagged without touching memory. The pipeline stalls while ReqReady is low.

Parameters:
ADDR_W, 10, word-address width of the data RAM; MemAddr = Addr[ADDR_W+1:2]

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
ReqValid  in  1  access request from MEM stage
ReqWrite  in  1  1 = store, 0 = load
LoadType  in  3  0 LW, 1 LH, 2 LHU, 3 LB, 4 LBU; 5-7 illegal
StoreType  in  2  0 SW, 1 SH, 2 SB; 3 illegal
Addr  in  32  byte address
WriteData  in  32  store data; sub-word stores use the low bits
ReqReady  out  1  high only in IDLE; request accepted when ReqValid && ReqReady
RespValid  out  1  one-cycle completion pulse
RespData  out  32  extracted load data; 0 for stores and errors
AddrErr  out  1  high with RespValid when the access was rejected
MemAddr  out  ADDR_W  RAM word address
MemRE  out  1  RAM read strobe; MemRData valid the next cycle
MemWE  out  1  RAM write strobe
MemWData  out  32  RAM write data
MemRData  in  32  RAM read data

Behaviour:
- Reset (rst high at clk edge): state IDLE. Request/data registers cleared.
- Values after reset: ReqReady=1, RespValid=0, AddrErr=0, RespData=0, MemRE=0, MemWE=0, MemAddr=0, MemWData=0.
- All outputs are decoded from the state register and internal registers (Moore). No combinational path from request inputs to outputs.
- States: IDLE, RD, WAIT, WR, DONE, ERR.
- IDLE: accepts a request. The access is illegal if any of these hold:
  - LW/SW with Addr[1:0]!=0
  - LH/LHU/SH with Addr[0]!=0
  - LoadType>4 on a load, or StoreType==3 on a store
- IDLE transitions:
  - illegal -> ERR
  - SW -> WR
  - any load, SH, SB -> RD
  - Addr, WriteData, types and direction are latched on acceptance.
- RD: MemRE=1, MemAddr=latched word address. -> WAIT.
- WAIT: MemRData is captured into the data register.
  - load: the extracted value is registered into RespData. -> DONE.
  - SH/SB: the merged word is registered. -> WR.
- WR: MemWE=1, MemAddr=latched word address.
  - SW: MemWData=WriteData.
  - SH/SB: MemWData=merged word.
  - -> DONE.
- DONE: RespValid=1, RespData valid (0 for stores). -> IDLE.
- ERR: RespValid=1, AddrErr=1, RespData=0. MemRE and MemWE stay 0. -> IDLE.
- Little-endian lane mapping, off=Addr[1:0]:
  - byte lane k = bits [8k+7:8k]
  - half lane at off=0 = [15:0], at off=2 = [31:16]
- Extraction: LW returns the full word. LH/LB sign-extend to 32 bits. LHU/LBU zero-extend.
- Merge: only the addressed lane is replaced, by WriteData[15:0] (SH) or WriteData[7:0] (SB). All other bits come from MemRData.
- Latency from the acceptance cycle T to RespValid:
  - error T+1
  - SW T+2
  - load T+3
  - SH/SB T+4
- Next acceptance is possible in the cycle after DONE or ERR.
- ReqValid and all request inputs are ignored outside IDLE. A held ReqValid is re-sampled only in IDLE.
- Outside RD, MemRE=0. Outside WR, MemWE=0.
- MemAddr and MemWData hold their last value when no strobe is active.
- Reset mid-operation aborts the access: no MemWE is issued afterwards and no RespValid is produced for the aborted request.
- Simultaneous rst and ReqValid: reset wins and the request is not accepted.

Test Plan:
1. SW, Addr=0x10, WriteData=0xDEADBEEF -> at T+1 MemWE=1, MemAddr=4, MemWData=0xDEADBEEF; at T+2 RespValid=1, RespData=0, AddrErr=0.
2. LB, Addr=0x13, MemRData=0x80123456 -> MemRE at T+1, MemAddr=4; RespData=0xFFFFFF80 at T+3. Repeat with LBU -> 0x00000080. LH Addr=0x2 with MemRData=0x80010000 -> 0xFFFF8001.
3. SH, Addr=0x12, WriteData=0x0000ABCD, MemRData=0x11223344 -> MemRE at T+1, MemWE at T+3 with MemWData=0xABCD3344, RespValid at T+4. SB Addr=0x11 WriteData=0xEE, same RAM word -> MemWData=0x1122EE44.
4. LW Addr=0x6, LH Addr=0x3, and LoadType=5 Addr=0x0 (each separately) -> RespValid=1 and AddrErr=1 at T+1, RespData=0; MemRE and MemWE never asserted.
5. SB issued, rst asserted during WAIT -> MemWE never rises; cycle after reset ReqReady=1, RespValid=0.
6. ReqValid held high with two consecutive LW requests -> ReqReady=0 from T+1 to T+3; second request accepted at T+4; one RespValid pulse per request.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory sequencer over a single-port, word-wide synchronous RAM.
// Sub-word loads extract from a word read; sub-word stores use read-modify-write.
module mem_access_ctrl #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ReqValid,
    input  logic              ReqWrite,
    input  logic [2:0]        LoadType,
    input  logic [1:0]        StoreType,
    input  logic [31:0]       Addr,
    input  logic [31:0]       WriteData,
    output logic              ReqReady,
    output logic              RespValid,
    output logic [31:0]       RespData,
    output logic              AddrErr,
    output logic [ADDR_W-1:0] MemAddr,
    output logic              MemRE,
    output logic              MemWE,
    output logic [31:0]       MemWData,
    input  logic [31:0]       MemRData
);

    typedef enum logic [2:0] {IDLE, RD, WAIT, WR, DONE, ERR} stateT;

    stateT       state;
    logic        isWrite;
    logic [2:0]  loadKind;
    logic [1:0]  storeKind;
    logic [1:0]  byteOff;
    logic [15:0] storeLow;

    logic        illegal;
    logic [7:0]  selByte;
    logic [15:0] selHalf;
    logic [31:0] loadValue;
    logic [31:0] mergedWord;

    // Address bits above the RAM's reach are intentionally ignored.
    logic unusedAddrBits;
    assign unusedAddrBits = ^Addr[31:ADDR_W+2];

    always_comb begin
        illegal = 1'b0;
        if (ReqWrite) begin
            case (StoreType)
                2'd0:    illegal = (Addr[1:0] != 2'b00);
                2'd1:    illegal = Addr[0];
                2'd2:    illegal = 1'b0;
                default: illegal = 1'b1;
            endcase
        end else begin
            case (LoadType)
                3'd0:       illegal = (Addr[1:0] != 2'b00);
                3'd1, 3'd2: illegal = Addr[0];
                3'd3, 3'd4: illegal = 1'b0;
                default:    illegal = 1'b1;
            endcase
        end
    end

    // Lane selection is little-endian; byteOff picks the lane within the word.
    always_comb begin
        selByte    = MemRData[{byteOff, 3'b000} +: 8];
        selHalf    = byteOff[1] ? MemRData[31:16] : MemRData[15:0];
        loadValue  = 32'h0;
        case (loadKind)
            3'd0:    loadValue = MemRData;
            3'd1:    loadValue = {{16{selHalf[15]}}, selHalf};
            3'd2:    loadValue = {16'h0, selHalf};
            3'd3:    loadValue = {{24{selByte[7]}}, selByte};
            3'd4:    loadValue = {24'h0, selByte};
            default: loadValue = 32'h0;
        endcase
        mergedWord = MemRData;
        if (storeKind == 2'd1) begin
            if (byteOff[1]) mergedWord[31:16] = storeLow;
            else            mergedWord[15:0]  = storeLow;
        end else begin
            mergedWord[{byteOff, 3'b000} +: 8] = storeLow[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            isWrite   <= 1'b0;
            loadKind  <= 3'd0;
            storeKind <= 2'd0;
            byteOff   <= 2'd0;
            storeLow  <= 16'h0;
            ReqReady  <= 1'b1;
            RespValid <= 1'b0;
            RespData  <= 32'h0;
            AddrErr   <= 1'b0;
            MemAddr   <= '0;
            MemRE     <= 1'b0;
            MemWE     <= 1'b0;
            MemWData  <= 32'h0;
        end else begin
            RespValid <= 1'b0;
            AddrErr   <= 1'b0;
            MemRE     <= 1'b0;
            MemWE     <= 1'b0;
            case (state)
                IDLE: begin
                    if (ReqValid) begin
                        isWrite   <= ReqWrite;
                        loadKind  <= LoadType;
                        storeKind <= StoreType;
                        byteOff   <= Addr[1:0];
                        storeLow  <= WriteData[15:0];
                        ReqReady  <= 1'b0;
                        RespData  <= 32'h0;
                        if (illegal) begin
                            state     <= ERR;
                            RespValid <= 1'b1;
                            AddrErr   <= 1'b1;
                        end else if (ReqWrite && StoreType == 2'd0) begin
                            state    <= WR;
                            MemWE    <= 1'b1;
                            MemAddr  <= Addr[ADDR_W+1:2];
                            MemWData <= WriteData;
                        end else begin
                            state   <= RD;
                            MemRE   <= 1'b1;
                            MemAddr <= Addr[ADDR_W+1:2];
                        end
                    end
                end
                RD: state <= WAIT;
                WAIT: begin
                    if (isWrite) begin
                        state    <= WR;
                        MemWE    <= 1'b1;
                        MemWData <= mergedWord;
                    end else begin
                        state     <= DONE;
                        RespValid <= 1'b1;
                        RespData  <= loadValue;
                    end
                end
                WR: begin
                    state     <= DONE;
                    RespValid <= 1'b1;
                    RespData  <= 32'h0;
                end
                DONE, ERR: begin
                    state    <= IDLE;
                    ReqReady <= 1'b1;
                    RespData <= 32'h0;
                end
                default: begin
                    state    <= IDLE;
                    ReqReady <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: responses and RAM strobes are queued
// as expectations when requests are driven and popped when the DUT emits them.
module tb_mem_access_ctrl;

    localparam int ADDR_W = 10;

    logic              clk = 1'b0;
    logic              rst;
    logic              ReqValid;
    logic              ReqWrite;
    logic [2:0]        LoadType;
    logic [1:0]        StoreType;
    logic [31:0]       Addr;
    logic [31:0]       WriteData;
    logic              ReqReady;
    logic              RespValid;
    logic [31:0]       RespData;
    logic              AddrErr;
    logic [ADDR_W-1:0] MemAddr;
    logic              MemRE;
    logic              MemWE;
    logic [31:0]       MemWData;
    logic [31:0]       MemRData;

    mem_access_ctrl #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .ReqValid(ReqValid), .ReqWrite(ReqWrite),
        .LoadType(LoadType), .StoreType(StoreType), .Addr(Addr),
        .WriteData(WriteData), .ReqReady(ReqReady), .RespValid(RespValid),
        .RespData(RespData), .AddrErr(AddrErr), .MemAddr(MemAddr),
        .MemRE(MemRE), .MemWE(MemWE), .MemWData(MemWData), .MemRData(MemRData)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] data;
        logic        err;
    } respT;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } writeT;

    respT              respQ[$];
    writeT             writeQ[$];
    logic [ADDR_W-1:0] readQ[$];

    int checks = 0;
    int passed = 0;
    int cyc = 0;
    int reCyc, weCyc, respCyc;
    int respCount = 0;

    always @(posedge clk) cyc++;

    // Scoreboard: every strobe or response the DUT emits must match the oldest expectation.
    always @(negedge clk) begin
        respT  expResp;
        writeT expWrite;
        logic [ADDR_W-1:0] expRead;
        if (RespValid === 1'b1) begin
            respCount++;
            respCyc = cyc;
            checks++;
            if (respQ.size() == 0) begin
                $display("[TB] FAIL resp_unexpected: RespData=%h AddrErr=%b, none pending", RespData, AddrErr);
            end else begin
                expResp = respQ.pop_front();
                if (RespData !== expResp.data || AddrErr !== expResp.err)
                    $display("[TB] FAIL resp: got data=%h err=%b, want data=%h err=%b",
                             RespData, AddrErr, expResp.data, expResp.err);
                else passed++;
            end
        end
        if (MemRE === 1'b1) begin
            reCyc = cyc;
            checks++;
            if (readQ.size() == 0) begin
                $display("[TB] FAIL read_unexpected: MemAddr=%h", MemAddr);
            end else begin
                expRead = readQ.pop_front();
                if (MemAddr !== expRead)
                    $display("[TB] FAIL read_addr: got %h, want %h", MemAddr, expRead);
                else passed++;
            end
        end
        if (MemWE === 1'b1) begin
            weCyc = cyc;
            checks++;
            if (writeQ.size() == 0) begin
                $display("[TB] FAIL write_unexpected: MemAddr=%h MemWData=%h", MemAddr, MemWData);
            end else begin
                expWrite = writeQ.pop_front();
                if (MemAddr !== expWrite.addr || MemWData !== expWrite.data)
                    $display("[TB] FAIL write: got addr=%h data=%h, want addr=%h data=%h",
                             MemAddr, MemWData, expWrite.addr, expWrite.data);
                else passed++;
            end
        end
    end

    // Drives one request for a single accepted cycle; tAcc is the acceptance cycle.
    task automatic sendReq(input logic wr, input logic [2:0] lt, input logic [1:0] st,
                           input logic [31:0] a, input logic [31:0] wd, output int tAcc);
        @(negedge clk);
        reCyc = -1; weCyc = -1; respCyc = -1;
        ReqWrite = wr; LoadType = lt; StoreType = st; Addr = a; WriteData = wd;
        ReqValid = 1'b1;
        @(posedge clk);
        #1;
        ReqValid = 1'b0;
        tAcc = cyc - 1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (ReqReady !== 1'b1) $display("[TB] FAIL rst_ReqReady: got %b want 1", ReqReady); else passed++;
        checks++; if (RespValid !== 1'b0) $display("[TB] FAIL rst_RespValid: got %b want 0", RespValid); else passed++;
        checks++; if (AddrErr !== 1'b0) $display("[TB] FAIL rst_AddrErr: got %b want 0", AddrErr); else passed++;
        checks++; if (RespData !== 32'h0) $display("[TB] FAIL rst_RespData: got %h want 0", RespData); else passed++;
        checks++; if (MemRE !== 1'b0) $display("[TB] FAIL rst_MemRE: got %b want 0", MemRE); else passed++;
        checks++; if (MemWE !== 1'b0) $display("[TB] FAIL rst_MemWE: got %b want 0", MemWE); else passed++;
        checks++; if (MemAddr !== '0) $display("[TB] FAIL rst_MemAddr: got %h want 0", MemAddr); else passed++;
        checks++; if (MemWData !== 32'h0) $display("[TB] FAIL rst_MemWData: got %h want 0", MemWData); else passed++;
        rst = 1'b0;
    endtask

    task automatic test_store_word();
        int tAcc;
        respQ.push_back('{32'h0, 1'b0});
        writeQ.push_back('{10'd4, 32'hDEADBEEF});
        sendReq(1'b1, 3'd0, 2'd0, 32'h10, 32'hDEADBEEF, tAcc);
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (weCyc - tAcc !== 1 || respCyc - tAcc !== 2 || reCyc !== -1)
            $display("[TB] FAIL sw_timing: we=%0d resp=%0d re=%0d, want we=1 resp=2 re=none",
                     weCyc - tAcc, respCyc - tAcc, reCyc);
        else passed++;
        checks++;
        if (MemAddr !== 10'd4 || MemWData !== 32'hDEADBEEF || MemWE !== 1'b0)
            $display("[TB] FAIL sw_hold: addr=%h data=%h we=%b, want 004 deadbeef 0", MemAddr, MemWData, MemWE);
        else passed++;
    endtask

    task automatic test_loads();
        logic [2:0]  lts[6]   = '{3'd3, 3'd4, 3'd1, 3'd2, 3'd0, 3'd3};
        logic [31:0] addrs[6] = '{32'h13, 32'h13, 32'h2, 32'h2, 32'h8, 32'h10};
        logic [31:0] rams[6]  = '{32'h80123456, 32'h80123456, 32'h80010000,
                                  32'h80010000, 32'h80010000, 32'h80123456};
        logic [31:0] exps[6]  = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8001,
                                  32'h00008001, 32'h80010000, 32'h00000056};
        int tAcc;
        for (int i = 0; i < 6; i++) begin
            MemRData = rams[i];
            respQ.push_back('{exps[i], 1'b0});
            readQ.push_back(addrs[i][ADDR_W+1:2]);
            sendReq(1'b0, lts[i], 2'd0, addrs[i], 32'h0, tAcc);
            repeat (5) @(posedge clk);
            #1;
            checks++;
            if (reCyc - tAcc !== 1 || respCyc - tAcc !== 3 || weCyc !== -1)
                $display("[TB] FAIL load_timing[%0d]: re=%0d resp=%0d we=%0d, want re=1 resp=3 we=none",
                         i, reCyc - tAcc, respCyc - tAcc, weCyc);
            else passed++;
        end
    endtask

    task automatic test_subword_store();
        logic [1:0]  sts[4]   = '{2'd1, 2'd2, 2'd1, 2'd2};
        logic [31:0] addrs[4] = '{32'h12, 32'h11, 32'h10, 32'h13};
        logic [31:0] wds[4]   = '{32'h0000ABCD, 32'h000000EE, 32'hFFFF1234, 32'h12345699};
        logic [31:0] exps[4]  = '{32'hABCD3344, 32'h1122EE44, 32'h11221234, 32'h99223344};
        int tAcc;
        MemRData = 32'h11223344;
        for (int i = 0; i < 4; i++) begin
            respQ.push_back('{32'h0, 1'b0});
            readQ.push_back(addrs[i][ADDR_W+1:2]);
            writeQ.push_back('{addrs[i][ADDR_W+1:2], exps[i]});
            sendReq(1'b1, 3'd0, sts[i], addrs[i], wds[i], tAcc);
            repeat (5) @(posedge clk);
            #1;
            checks++;
            if (reCyc - tAcc !== 1 || weCyc - tAcc !== 3 || respCyc - tAcc !== 4)
                $display("[TB] FAIL rmw_timing[%0d]: re=%0d we=%0d resp=%0d, want 1 3 4",
                         i, reCyc - tAcc, weCyc - tAcc, respCyc - tAcc);
            else passed++;
        end
    endtask

    task automatic test_errors();
        logic        wrs[8]   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [2:0]  lts[8]   = '{3'd0, 3'd1, 3'd5, 3'd7, 3'd0, 3'd0, 3'd0, 3'd2};
        logic [1:0]  sts[8]   = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd3, 2'd0};
        logic [31:0] addrs[8] = '{32'h6, 32'h3, 32'h0, 32'h4, 32'h2, 32'h1, 32'h0, 32'h1};
        int tAcc;
        for (int i = 0; i < 8; i++) begin
            respQ.push_back('{32'h0, 1'b1});
            sendReq(wrs[i], lts[i], sts[i], addrs[i], 32'hCAFEF00D, tAcc);
            repeat (4) @(posedge clk);
            #1;
            checks++;
            if (respCyc - tAcc !== 1 || reCyc !== -1 || weCyc !== -1)
                $display("[TB] FAIL err_timing[%0d]: resp=%0d re=%0d we=%0d, want resp=1 no strobes",
                         i, respCyc - tAcc, reCyc, weCyc);
            else passed++;
        end
    endtask

    task automatic test_reset_abort();
        int tAcc;
        MemRData = 32'h11223344;
        readQ.push_back(10'd4);
        sendReq(1'b1, 3'd0, 2'd2, 32'h11, 32'h000000EE, tAcc);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (ReqReady !== 1'b1) $display("[TB] FAIL abort_ReqReady: got %b want 1", ReqReady); else passed++;
        checks++; if (RespValid !== 1'b0) $display("[TB] FAIL abort_RespValid: got %b want 0", RespValid); else passed++;
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (reCyc - tAcc !== 1 || weCyc !== -1 || respCyc !== -1)
            $display("[TB] FAIL abort_strobes: re=%0d we=%0d resp=%0d, want re=1 we=none resp=none",
                     reCyc - tAcc, weCyc, respCyc);
        else passed++;

        @(negedge clk);
        reCyc = -1; weCyc = -1; respCyc = -1;
        ReqWrite = 1'b0; LoadType = 3'd0; Addr = 32'h0;
        rst = 1'b1; ReqValid = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0; ReqValid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (reCyc !== -1 || weCyc !== -1 || respCyc !== -1)
            $display("[TB] FAIL rst_wins: re=%0d we=%0d resp=%0d, want no activity", reCyc, weCyc, respCyc);
        else passed++;
    endtask

    task automatic test_back_to_back();
        int tAcc;
        int cnt0;
        MemRData = 32'h12345678;
        respQ.push_back('{32'h12345678, 1'b0});
        respQ.push_back('{32'h12345678, 1'b0});
        readQ.push_back(10'd8);
        readQ.push_back(10'd9);
        @(negedge clk);
        reCyc = -1; weCyc = -1; respCyc = -1;
        cnt0 = respCount;
        ReqWrite = 1'b0; LoadType = 3'd0; StoreType = 2'd0; Addr = 32'h20;
        ReqValid = 1'b1;
        @(posedge clk);
        #1;
        tAcc = cyc - 1;
        Addr = 32'h24;
        for (int k = 1; k <= 4; k++) begin
            checks++;
            if (ReqReady !== (k == 4))
                $display("[TB] FAIL b2b_ReqReady[T+%0d]: got %b want %b", k, ReqReady, (k == 4));
            else passed++;
            if (k < 4) begin
                @(posedge clk);
                #1;
            end
        end
        @(posedge clk);
        #1;
        ReqValid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (respCount - cnt0 !== 2 || reCyc - tAcc !== 5 || respCyc - tAcc !== 7)
            $display("[TB] FAIL b2b_second: resps=%0d re=%0d resp=%0d, want 2 5 7",
                     respCount - cnt0, reCyc - tAcc, respCyc - tAcc);
        else passed++;
    endtask

    initial begin
        ReqValid = 1'b0; ReqWrite = 1'b0; LoadType = 3'd0; StoreType = 2'd0;
        Addr = 32'h0; WriteData = 32'h0; MemRData = 32'h0;
        reCyc = -1; weCyc = -1; respCyc = -1;
        test_reset();
        test_store_word();
        test_loads();
        test_subword_store();
        test_errors();
        test_reset_abort();
        test_back_to_back();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (respQ.size() != 0 || readQ.size() != 0 || writeQ.size() != 0)
            $display("[TB] FAIL scoreboard_drain: resp=%0d read=%0d write=%0d left, want 0",
                     respQ.size(), readQ.size(), writeQ.size());
        else passed++;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
